// File: rtl/opb_register_bank_simulink2ppc_pkg.sv
// Shared register map and bit positions for the simulink-to-PPC register bank.
// Bit positions use OPB numbering (bit 0 = MSB, bit 31 = LSB).
package opb_register_bank_simulink2ppc_pkg;

    // Byte offsets from C_BASEADDR
    localparam logic [31:0] CTRL_OFF   = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFF = 32'h0000_0004;
    localparam logic [31:0] CH0_OFF    = 32'h0000_0008;

    // CTRL word
    localparam int CTRL_MODE_BIT = 31;  // 0 live, 1 snapshot
    localparam int CTRL_ARM_BIT  = 30;  // write-1 arms a snapshot, reads 0

    // STATUS word
    localparam int STAT_CNT_FIRST = 0;   // count occupies bits 0..15 (MSB first)
    localparam int STAT_CNT_LAST  = 15;
    localparam int STAT_CAPT_BIT  = 30;
    localparam int STAT_ARMED_BIT = 31;

    // Byte enable guarding the CTRL byte that holds mode/ARM
    localparam int BE_CTRL_BYTE = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } bus_state_e;

    // Byte offset of user channel i
    function automatic logic [31:0] ch_offset(input int i);
        return CH0_OFF + 32'(4 * i);
    endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// OPB slave front end: address decode, IDLE/ACK handshake and request capture.
// Read data is taken from the register mux in the hit cycle so the master sees
// the value as it stood when the transfer was accepted.
module opb_slave_ack_fsm
    import opb_register_bank_simulink2ppc_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR = 32'h0100_2100,
    parameter logic [31:0] C_HIGHADDR = 32'h0100_21FF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [0:31] abus_i,
    input  logic [0:3]  be_i,
    input  logic [0:31] dbus_i,
    input  logic        rnw_i,
    input  logic        select_i,
    input  logic [0:31] rd_data_i,
    output logic        ack_o,
    output logic [0:31] req_addr_o,
    output logic        req_rnw_o,
    output logic [0:3]  req_be_o,
    output logic [0:31] req_dbus_o,
    output logic [0:31] sl_dbus_o
);

    bus_state_e  state_q, state_d;
    logic        hit;
    logic        in_range;
    logic [0:31] addr_q, addr_d;
    logic        rnw_q, rnw_d;
    logic [0:3]  be_q, be_d;
    logic [0:31] dbus_q, dbus_d;
    logic [0:31] rdata_q, rdata_d;

    assign in_range = (abus_i >= C_BASEADDR) && (abus_i <= C_HIGHADDR);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state: a hit moves to ACK, ACK always returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (hit) state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: hits only accepted in IDLE, read data gated to the ack cycle
    always_comb begin
        hit       = select_i && in_range && (state_q == ST_IDLE);
        ack_o     = (state_q == ST_ACK);
        sl_dbus_o = (ack_o && rnw_q) ? rdata_q : '0;
    end

    // Request capture next-state: load everything on the hit
    always_comb begin
        addr_d  = addr_q;
        rnw_d   = rnw_q;
        be_d    = be_q;
        dbus_d  = dbus_q;
        rdata_d = rdata_q;
        if (hit) begin
            addr_d  = abus_i;
            rnw_d   = rnw_i;
            be_d    = be_i;
            dbus_d  = dbus_i;
            rdata_d = rd_data_i;
        end
    end

    // Request registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            rnw_q   <= 1'b0;
            be_q    <= '0;
            dbus_q  <= '0;
            rdata_q <= '0;
        end else begin
            addr_q  <= addr_d;
            rnw_q   <= rnw_d;
            be_q    <= be_d;
            dbus_q  <= dbus_d;
            rdata_q <= rdata_d;
        end
    end

    assign req_addr_o = addr_q;
    assign req_rnw_o  = rnw_q;
    assign req_be_o   = be_q;
    assign req_dbus_o = dbus_q;

endmodule

// File: rtl/opb_register_bank_simulink2ppc.sv
// Read-only bank of C_NUM_CH user words exposed to the PPC over OPB, with a
// live/snapshot capture mode, a self-clearing ARM bit and a capture counter so
// software can read multi-word fabric state coherently.
module opb_register_bank_simulink2ppc
    import opb_register_bank_simulink2ppc_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0100_2100,
    parameter logic [31:0] C_HIGHADDR   = 32'h0100_21FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_CH     = 4,
    parameter string       C_FAMILY     = "virtex6"
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst,
    input  logic [0:31]             OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:31]             OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:31]             Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    input  logic [C_NUM_CH*32-1:0]  user_data_in,
    input  logic                    user_valid
);

    // Widths and family are fixed by the bus; they carry no logic here.
    localparam int    unused_widths = C_OPB_AWIDTH + C_OPB_DWIDTH;
    localparam string unused_family = C_FAMILY;

    logic                       ack;
    logic [0:31]                req_addr;
    logic                       req_rnw;
    logic [0:3]                 req_be;
    logic [0:31]                req_dbus;
    logic [0:31]                rd_mux;
    logic [31:0]                hit_off;
    logic [31:0]                req_off;

    logic                       mode_q, mode_d;
    logic                       armed_q, armed_d;
    logic                       captured_q, captured_d;
    logic [15:0]                count_q, count_d;
    logic [C_NUM_CH-1:0][31:0]  shadow_q, shadow_d;

    logic                       ctrl_wr;
    logic                       arm_wr;
    logic                       capture;
    logic                       load;
    logic                       unused_ok;

    assign unused_ok = ^{OPB_seqAddr, req_dbus[0:29], req_be[0:2]};

    opb_slave_ack_fsm #(
        .C_BASEADDR (C_BASEADDR),
        .C_HIGHADDR (C_HIGHADDR)
    ) u_ack_fsm (
        .clk_i      (OPB_Clk),
        .rst_i      (OPB_Rst),
        .abus_i     (OPB_ABus),
        .be_i       (OPB_BE),
        .dbus_i     (OPB_DBus),
        .rnw_i      (OPB_RNW),
        .select_i   (OPB_select),
        .rd_data_i  (rd_mux),
        .ack_o      (ack),
        .req_addr_o (req_addr),
        .req_rnw_o  (req_rnw),
        .req_be_o   (req_be),
        .req_dbus_o (req_dbus),
        .sl_dbus_o  (Sl_DBus)
    );

    assign Sl_xferAck = ack;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    assign hit_off = OPB_ABus - C_BASEADDR;
    assign req_off = req_addr - C_BASEADDR;

    // Register read mux, addressed by the live bus address (sampled at the hit)
    always_comb begin
        rd_mux = '0;
        if (hit_off == CTRL_OFF) begin
            rd_mux[CTRL_MODE_BIT] = mode_q;
        end else if (hit_off == STATUS_OFF) begin
            rd_mux[STAT_CNT_FIRST:STAT_CNT_LAST] = count_q;
            rd_mux[STAT_CAPT_BIT]                = captured_q;
            rd_mux[STAT_ARMED_BIT]               = armed_q;
        end else begin
            for (int i = 0; i < C_NUM_CH; i++) begin
                if (hit_off == ch_offset(i)) rd_mux = shadow_q[i];
            end
        end
    end

    // CTRL writes land in the ack cycle; an ARM write suppresses any capture
    // in that same cycle so software never sees a stale-armed snapshot.
    assign ctrl_wr = ack && !req_rnw && (req_off == CTRL_OFF) && req_be[BE_CTRL_BYTE];
    assign arm_wr  = ctrl_wr && req_dbus[CTRL_ARM_BIT];
    assign capture = mode_q && armed_q && user_valid && !arm_wr;
    assign load    = (!mode_q && user_valid) || capture;

    // Capture and control next-state; the CTRL write is applied last so it wins
    always_comb begin
        mode_d     = mode_q;
        armed_d    = armed_q;
        captured_d = captured_q;
        count_d    = count_q;
        shadow_d   = shadow_q;
        if (load) shadow_d = user_data_in;
        if (capture) begin
            armed_d    = 1'b0;
            captured_d = 1'b1;
            count_d    = count_q + 16'd1;
        end
        if (ctrl_wr) begin
            mode_d = req_dbus[CTRL_MODE_BIT];
            if (req_dbus[CTRL_ARM_BIT]) begin
                armed_d    = 1'b1;
                captured_d = 1'b0;
            end
            // Dropping back to live mode disarms any pending snapshot
            if (!req_dbus[CTRL_MODE_BIT]) armed_d = 1'b0;
        end
    end

    // Capture/control state registers
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            mode_q     <= 1'b0;
            armed_q    <= 1'b0;
            captured_q <= 1'b0;
            count_q    <= '0;
            shadow_q   <= '0;
        end else begin
            mode_q     <= mode_d;
            armed_q    <= armed_d;
            captured_q <= captured_d;
            count_q    <= count_d;
            shadow_q   <= shadow_d;
        end
    end

endmodule

// File: tb/tb_opb_register_bank_simulink2ppc.sv
// Self-checking bench for opb_register_bank_simulink2ppc: randomized user data
// checked against a behavioural model of the register bank.
module tb_opb_register_bank_simulink2ppc;

    localparam int          NCH  = 4;
    localparam logic [31:0] BASE = 32'h0100_2100;
    localparam logic [31:0] HIGH = 32'h0100_21FF;

    logic               clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic [0:31]        abus;
    logic [0:3]         be;
    logic [0:31]        dbus;
    logic               rnw, sel, seq;
    logic [0:31]        sl_dbus;
    logic               xack, eack, rtry, tsup;
    logic [NCH*32-1:0]  udata;
    logic               uvalid;

    int tests = 0;
    int fails = 0;

    opb_register_bank_simulink2ppc #(
        .C_BASEADDR (BASE),
        .C_HIGHADDR (HIGH),
        .C_NUM_CH   (NCH)
    ) dut (
        .OPB_Clk      (clk),
        .OPB_Rst      (rst),
        .OPB_ABus     (abus),
        .OPB_BE       (be),
        .OPB_DBus     (dbus),
        .OPB_RNW      (rnw),
        .OPB_select   (sel),
        .OPB_seqAddr  (seq),
        .Sl_DBus      (sl_dbus),
        .Sl_xferAck   (xack),
        .Sl_errAck    (eack),
        .Sl_retry     (rtry),
        .Sl_toutSup   (tsup),
        .user_data_in (udata),
        .user_valid   (uvalid)
    );

    // ---------------- behavioural model ----------------
    bit          m_mode, m_armed, m_capt;
    int unsigned m_cnt;
    logic [31:0] m_sh [NCH];

    function automatic void m_reset();
        m_mode = 0; m_armed = 0; m_capt = 0; m_cnt = 0;
        for (int i = 0; i < NCH; i++) m_sh[i] = '0;
    endfunction

    function automatic void m_valid(input logic [NCH*32-1:0] d);
        if (!m_mode || m_armed) begin
            for (int i = 0; i < NCH; i++) m_sh[i] = d[32*i +: 32];
            if (m_mode) begin
                m_armed = 0; m_capt = 1; m_cnt = (m_cnt + 1) % 65536;
            end
        end
    endfunction

    // be_v[0] is OPB BE[3], the byte carrying mode/ARM
    function automatic void m_write(input logic [31:0] off, input logic [3:0] be_v, input logic [31:0] wd);
        if (off == 0 && be_v[0]) begin
            m_mode = wd[0];
            if (wd[1]) begin m_armed = 1; m_capt = 0; end
            if (!m_mode) m_armed = 0;
        end
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] off);
        int idx;
        if (off == 0) return m_mode ? 32'd1 : 32'd0;
        if (off == 4) return 32'(m_cnt) * 32'd65536 + (m_capt ? 32'd2 : 32'd0) + (m_armed ? 32'd1 : 32'd0);
        if (off >= 8 && off < 32'(8 + 4 * NCH) && off % 4 == 0) begin
            idx = int'((off - 8) / 4);
            return m_sh[idx];
        end
        return 32'd0;
    endfunction

    function automatic logic [NCH*32-1:0] rand_vec();
        logic [NCH*32-1:0] v;
        for (int i = 0; i < NCH; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // ---------------- bus/user drivers ----------------
    // hs is 1 only if ack was 0 before the hit, 1 exactly one cycle later, 0
    // again after, and Sl_DBus was 0 outside a read ack. vstage places a
    // user_valid pulse in the hit cycle (1) or the ack cycle (2).
    task automatic xfer(input logic [31:0] off, input bit rd, input logic [3:0] be_v,
                        input logic [31:0] wd, input int vstage, input logic [NCH*32-1:0] vd,
                        output bit hs, output logic [31:0] rdv);
        @(negedge clk);
        hs = (xack === 1'b0) && (sl_dbus === '0);
        sel = 1'b1; abus = BASE + off; rnw = rd; be = be_v; dbus = wd;
        if (vstage == 1) begin uvalid = 1'b1; udata = vd; end
        @(negedge clk);
        hs = hs && (xack === 1'b1) && (rd || sl_dbus === '0);
        rdv = sl_dbus;
        sel = 1'b0; abus = '0; rnw = 1'b0; be = '0; dbus = '0;
        uvalid = (vstage == 2);
        if (vstage == 2) udata = vd;
        @(negedge clk);
        hs = hs && (xack === 1'b0) && (sl_dbus === '0);
        uvalid = 1'b0;
    endtask

    task automatic pulse(input logic [NCH*32-1:0] d);
        @(negedge clk);
        uvalid = 1'b1; udata = d;
        @(negedge clk);
        uvalid = 1'b0;
        m_valid(d);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bit hs; logic [31:0] rdv, exp;
        logic [31:0] offs [3] = '{32'h0, 32'h4, 32'h8};
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({sl_dbus, xack, eack, rtry, tsup} !== '0) begin
            fails++; $display("FAIL reset_outputs: got dbus=%h ack=%b err=%b retry=%b tout=%b, want all 0",
                              sl_dbus, xack, eack, rtry, tsup);
        end
        rst = 1'b0;
        m_reset();
        foreach (offs[k]) begin
            exp = exp_read(offs[k]);
            xfer(offs[k], 1, 4'hF, 0, 0, '0, hs, rdv);
            tests++;
            if (!hs || rdv !== exp) begin
                fails++; $display("FAIL reset_read_%h: hs=%0b got=%h want=%h", offs[k], hs, rdv, exp);
            end
        end
    endtask

    task automatic test_live();
        bit hs; logic [31:0] rdv, exp, off;
        logic [NCH*32-1:0] d;
        // Plan case: ch2 = DEADBEEF, read offset 0x10
        d = rand_vec(); d[64 +: 32] = 32'hDEAD_BEEF;
        pulse(d);
        exp = exp_read(32'h10);
        xfer(32'h10, 1, 4'hF, 0, 0, '0, hs, rdv);
        tests++;
        if (!hs || rdv !== exp) begin
            fails++; $display("FAIL live_ch2: hs=%0b got=%h want=%h", hs, rdv, exp);
        end
        // Random data, sometimes without user_valid (shadow must hold)
        for (int n = 0; n < 10; n++) begin
            d = rand_vec();
            if ($urandom_range(0, 2) != 0) pulse(d);
            else begin @(negedge clk); udata = d; end
            off = 32'(8 + 4 * $urandom_range(0, NCH - 1));
            exp = exp_read(off);
            xfer(off, 1, 4'hF, 0, 0, '0, hs, rdv);
            tests++;
            if (!hs || rdv !== exp) begin
                fails++; $display("FAIL live_rand_%0d: off=%h hs=%0b got=%h want=%h", n, off, hs, rdv, exp);
            end
        end
        // Read whose hit cycle coincides with a load returns the old word
        d = rand_vec();
        exp = exp_read(32'h8);
        xfer(32'h8, 1, 4'hF, 0, 1, d, hs, rdv);
        m_valid(d);
        tests++;
        if (!hs || rdv !== exp) begin
            fails++; $display("FAIL live_read_pre_update: hs=%0b got=%h want=%h", hs, rdv, exp);
        end
        exp = exp_read(32'h8);
        xfer(32'h8, 1, 4'hF, 0, 0, '0, hs, rdv);
        tests++;
        if (!hs || rdv !== exp) begin
            fails++; $display("FAIL live_read_post_update: hs=%0b got=%h want=%h", hs, rdv, exp);
        end
    endtask

    task automatic test_snapshot();
        bit hs; logic [31:0] rdv, exp;
        logic [NCH*32-1:0] d;
        logic [31:0] offs [4] = '{32'h0, 32'h4, 32'h8, 32'h14};
        xfer(32'h0, 0, 4'hF, 32'h3, 0, '0, hs, rdv);
        m_write(32'h0, 4'hF, 32'h3);
        tests++;
        if (!hs) begin fails++; $display("FAIL snap_arm_write: handshake got bad, want 0-1-0"); end
        exp = exp_read(32'h4);
        xfer(32'h4, 1, 4'hF, 0, 0, '0, hs, rdv);
        tests++;
        if (!hs || rdv !== exp) begin
            fails++; $display("FAIL snap_status_armed: hs=%0b got=%h want=%h", hs, rdv, exp);
        end
        d = rand_vec(); d[31:0] = 32'h11; d[96 +: 32] = 32'h44;
        pulse(d);
        pulse(rand_vec());  // not armed any more: ignored
        foreach (offs[k]) begin
            exp = exp_read(offs[k]);
            xfer(offs[k], 1, 4'hF, 0, 0, '0, hs, rdv);
            tests++;
            if (!hs || rdv !== exp) begin
                fails++; $display("FAIL snap_read_%h: hs=%0b got=%h want=%h", offs[k], hs, rdv, exp);
            end
        end
    endtask

    task automatic test_arm_coincide();
        bit hs; logic [31:0] rdv, exp;
        logic [31:0] offs [2] = '{32'h4, 32'hC};
        // ARM write acked in the same cycle as user_valid: no capture
        xfer(32'h0, 0, 4'hF, 32'h3, 2, rand_vec(), hs, rdv);
        m_write(32'h0, 4'hF, 32'h3);
        foreach (offs[k]) begin
            exp = exp_read(offs[k]);
            xfer(offs[k], 1, 4'hF, 0, 0, '0, hs, rdv);
            tests++;
            if (!hs || rdv !== exp) begin
                fails++; $display("FAIL coincide_nocap_%h: hs=%0b got=%h want=%h", offs[k], hs, rdv, exp);
            end
        end
        pulse(rand_vec());
        foreach (offs[k]) begin
            exp = exp_read(offs[k]);
            xfer(offs[k], 1, 4'hF, 0, 0, '0, hs, rdv);
            tests++;
            if (!hs || rdv !== exp) begin
                fails++; $display("FAIL coincide_cap_%h: hs=%0b got=%h want=%h", offs[k], hs, rdv, exp);
            end
        end
    endtask

    task automatic test_wrap();
        bit hs; logic [31:0] rdv, exp;
        // Preload the counter near the top instead of 65k real captures
        @(negedge clk);
        force dut.count_q = 16'hFFFE;
        @(negedge clk);
        release dut.count_q;
        m_cnt = 32'hFFFE;
        for (int n = 0; n < 2; n++) begin
            xfer(32'h0, 0, 4'hF, 32'h3, 0, '0, hs, rdv);
            m_write(32'h0, 4'hF, 32'h3);
            pulse(rand_vec());
            exp = exp_read(32'h4);
            xfer(32'h4, 1, 4'hF, 0, 0, '0, hs, rdv);
            tests++;
            if (!hs || rdv !== exp) begin
                fails++; $display("FAIL wrap_status_%0d: hs=%0b got=%h want=%h", n, hs, rdv, exp);
            end
        end
    endtask

    task automatic test_ctrl_rules();
        bit hs; logic [31:0] rdv, exp;
        logic [31:0] offs [2] = '{32'h0, 32'h4};
        // Arm, then drop to live mode: armed must clear
        xfer(32'h0, 0, 4'hF, 32'h3, 0, '0, hs, rdv); m_write(32'h0, 4'hF, 32'h3);
        xfer(32'h0, 0, 4'hF, 32'h0, 0, '0, hs, rdv); m_write(32'h0, 4'hF, 32'h0);
        // BE[3] low: CTRL write ignored
        xfer(32'h0, 0, 4'hE, 32'h3, 0, '0, hs, rdv); m_write(32'h0, 4'hE, 32'h3);
        foreach (offs[k]) begin
            exp = exp_read(offs[k]);
            xfer(offs[k], 1, 4'hF, 0, 0, '0, hs, rdv);
            tests++;
            if (!hs || rdv !== exp) begin
                fails++; $display("FAIL ctrl_rules_%h: hs=%0b got=%h want=%h", offs[k], hs, rdv, exp);
            end
        end
    endtask

    task automatic test_unmapped();
        bit hs; logic [31:0] rdv, exp;
        logic [31:0] offs [4] = '{32'hF0, 32'h18, 32'h9, 32'h8};
        // Writes to a shadow word and to STATUS are acked and dropped
        xfer(32'h8, 0, 4'hF, $urandom, 0, '0, hs, rdv);
        tests++;
        if (!hs) begin fails++; $display("FAIL ro_write_ack: handshake got bad, want 0-1-0"); end
        xfer(32'h4, 0, 4'hF, 32'hFFFF_FFFF, 0, '0, hs, rdv);
        foreach (offs[k]) begin
            exp = exp_read(offs[k]);
            xfer(offs[k], 1, 4'hF, 0, 0, '0, hs, rdv);
            tests++;
            if (!hs || rdv !== exp) begin
                fails++; $display("FAIL unmapped_%h: hs=%0b got=%h want=%h", offs[k], hs, rdv, exp);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] addrs [2] = '{HIGH + 32'd1, BASE - 32'd4};
        int acks;
        foreach (addrs[k]) begin
            acks = 0;
            @(negedge clk);
            sel = 1'b1; abus = addrs[k]; rnw = 1'b1; be = 4'hF;
            repeat (4) begin
                @(negedge clk);
                if (xack !== 1'b0) acks++;
            end
            sel = 1'b0; abus = '0;
            tests++;
            if (acks != 0) begin
                fails++; $display("FAIL out_of_range_%h: got %0d acks, want 0", addrs[k], acks);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        int bad;
        bad = 0;
        exp = exp_read(32'h8);
        @(negedge clk);
        sel = 1'b1; abus = BASE + 32'h8; rnw = 1'b1; be = 4'hF;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (xack !== ((k % 2) == 0)) bad++;
            if (sl_dbus !== (((k % 2) == 0) ? exp : 32'd0)) bad++;
        end
        sel = 1'b0; abus = '0;
        @(negedge clk);
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL back_to_back: got %0d bad cycles, want ack 1-0-1-0-1-0 with data %h", bad, exp);
        end
    endtask

    task automatic test_reset_midxfer();
        bit hs; logic [31:0] rdv, exp;
        @(negedge clk);
        sel = 1'b1; abus = BASE; rnw = 1'b1; be = 4'hF; rst = 1'b1;
        @(negedge clk);
        tests++;
        if (xack !== 1'b0) begin
            fails++; $display("FAIL reset_midxfer_ack: got %b, want 0", xack);
        end
        sel = 1'b0; abus = '0; rst = 1'b0;
        m_reset();
        exp = exp_read(32'h4);
        xfer(32'h4, 1, 4'hF, 0, 0, '0, hs, rdv);
        tests++;
        if (!hs || rdv !== exp) begin
            fails++; $display("FAIL reset_midxfer_status: hs=%0b got=%h want=%h", hs, rdv, exp);
        end
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; abus = '0; be = '0; dbus = '0; rnw = 1'b0; seq = 1'b0;
        udata = '0; uvalid = 1'b0;
        m_reset();
        test_reset();
        test_live();
        test_back_to_back();
        test_snapshot();
        test_arm_coincide();
        test_unmapped();
        test_wrap();
        test_ctrl_rules();
        test_out_of_range();
        test_reset_midxfer();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
